// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states and frame constants.
// The PARITY state only exists when UART_TX_PARITY_EN is defined.
package uart_pkg;

    localparam int   UART_DATA_BITS = 8;
    localparam logic UART_IDLE      = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_TX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } uart_tx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with an extra pointer bit so full and empty can be told apart.
// The head entry is always visible on pop_data.
module uart_tx_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             push_fire;
    logic             pop_fire;

    assign full      = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                       (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign empty     = (wr_ptr_reg == rd_ptr_reg);
    assign level     = wr_ptr_reg - rd_ptr_reg;
    assign push_fire = push && !full;
    assign pop_fire  = pop && !empty;
    assign pop_data  = mem[rd_ptr_reg[AW-1:0]];

    // Storage is left out of reset so it can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (push_fire) begin
            mem[wr_ptr_reg[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push_fire) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_fire) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_fifo_ctrl.sv
// Buffered UART transmitter: byte FIFO feeding an LSB-first 8N1 / 8E1 serialiser.
// Define UART_TX_PARITY_EN to add the even-parity bit (8E1 frames).
module uart_tx_fifo_ctrl
    import uart_pkg::*;
#(
    parameter  int FIFO_DEPTH = 4,
    parameter  int DIV_WIDTH  = 16,
    localparam int LW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DIV_WIDTH-1:0] clk_div,
    input  logic                 in_valid,
    input  logic [7:0]           in_data,
    output logic                 in_ready,
    output logic                 uart_tx,
    output logic                 busy,
    output logic [LW-1:0]        fifo_level
);

    uart_tx_state_t              state_reg;
    logic [UART_DATA_BITS-1:0]   shift_reg;
    logic [2:0]                  bit_idx_reg;
    logic [DIV_WIDTH-1:0]        div_cnt_reg;
    logic [DIV_WIDTH-1:0]        div_lat_reg;
    logic                        tx_reg;
    logic                        busy_reg;
`ifdef UART_TX_PARITY_EN
    logic                        parity_reg;
`endif

    logic                        fifo_full;
    logic                        fifo_empty;
    logic [7:0]                  head_data;
    logic                        push;
    logic                        pop;
    logic                        bit_end;
    logic                        frame_slot;
    logic                        going_idle;
    logic                        line_value;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (in_data),
        .pop       (pop),
        .pop_data  (head_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign in_ready   = !fifo_full;
    assign push       = in_valid && in_ready;
    assign bit_end    = (div_cnt_reg == '0);
    // A new frame may only be launched from IDLE or on the final STOP cycle.
    assign frame_slot = (state_reg == ST_IDLE) || ((state_reg == ST_STOP) && bit_end);
    assign pop        = frame_slot && !fifo_empty;
    assign going_idle = frame_slot && fifo_empty;

    assign uart_tx    = tx_reg;
    assign busy       = busy_reg;

    always_comb begin
        line_value = UART_IDLE;
        case (state_reg)
            ST_START:  line_value = 1'b0;
            ST_DATA:   line_value = shift_reg[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: line_value = parity_reg;
`endif
            default:   line_value = UART_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            shift_reg   <= '0;
            bit_idx_reg <= '0;
            div_cnt_reg <= '0;
            div_lat_reg <= '0;
            tx_reg      <= UART_IDLE;
            busy_reg    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_reg  <= 1'b0;
`endif
        end else begin
            tx_reg   <= line_value;
            busy_reg <= push || !going_idle;

            if (pop) begin
                // Divisor is captured once per frame so mid-frame changes are ignored.
                state_reg   <= ST_START;
                shift_reg   <= head_data;
                div_lat_reg <= clk_div;
                div_cnt_reg <= clk_div;
                bit_idx_reg <= '0;
`ifdef UART_TX_PARITY_EN
                parity_reg  <= ^head_data;
`endif
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        div_cnt_reg <= '0;
                    end
                    ST_START: begin
                        if (bit_end) begin
                            state_reg   <= ST_DATA;
                            div_cnt_reg <= div_lat_reg;
                        end else begin
                            div_cnt_reg <= div_cnt_reg - 1'b1;
                        end
                    end
                    ST_DATA: begin
                        if (bit_end) begin
                            div_cnt_reg <= div_lat_reg;
                            shift_reg   <= {1'b0, shift_reg[UART_DATA_BITS-1:1]};
                            if (bit_idx_reg == 3'(UART_DATA_BITS - 1)) begin
                                bit_idx_reg <= '0;
`ifdef UART_TX_PARITY_EN
                                state_reg   <= ST_PARITY;
`else
                                state_reg   <= ST_STOP;
`endif
                            end else begin
                                bit_idx_reg <= bit_idx_reg + 1'b1;
                            end
                        end else begin
                            div_cnt_reg <= div_cnt_reg - 1'b1;
                        end
                    end
`ifdef UART_TX_PARITY_EN
                    ST_PARITY: begin
                        if (bit_end) begin
                            state_reg   <= ST_STOP;
                            div_cnt_reg <= div_lat_reg;
                        end else begin
                            div_cnt_reg <= div_cnt_reg - 1'b1;
                        end
                    end
`endif
                    ST_STOP: begin
                        if (bit_end) begin
                            state_reg <= ST_IDLE;
                        end else begin
                            div_cnt_reg <= div_cnt_reg - 1'b1;
                        end
                    end
                    default: begin
                        state_reg <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
